// File: rtl/wm_insert_ctrl_pkg.sv
// Shared types and constants for the watermark insertion sequencer.
// Holds the FSM state encoding, symbol/pixel widths and symbol unpacking.
package wm_insert_ctrl_pkg;

   localparam int WM_SYMS_PER_BYTE = 4;
   localparam int SYM_W            = 2;
   localparam int PIX_W            = 8;

   typedef enum logic [3:0] {
      IDLE,
      RD_WM,
      RD_CUR,
      RD_L,
      RD_U,
      RD_UL,
      CAP,
      EXEC,
      WR,
      DONE
   } state_t;

   // Symbol k of a packed watermark byte, LSB-first.
   function automatic logic [SYM_W-1:0] sym_sel(
      input logic [PIX_W-1:0] b,
      input logic [1:0]       k
   );
      return b[SYM_W*k +: SYM_W];
   endfunction

endpackage

// File: rtl/wm_insert_ctrl_if.sv
// Memory and datapath bus of the watermark insertion sequencer.
// master: the sequencer; slave: cover/wm RAMs, datapath and output RAM.
interface wm_insert_ctrl_if #(
   parameter int ADDR_W = 12
);
   import wm_insert_ctrl_pkg::*;

   logic                  cover_rd_en;
   logic [ADDR_W-1:0]     cover_rd_addr;
   logic [PIX_W-1:0]      cover_rd_data;

   logic                  wm_rd_en;
   logic [ADDR_W-3:0]     wm_rd_addr;
   logic [PIX_W-1:0]      wm_rd_data;

   logic [PIX_W-1:0]      dp_a1;
   logic [PIX_W-1:0]      dp_a2;
   logic [PIX_W-1:0]      dp_data1;
   logic [PIX_W-1:0]      dp_data2;
   logic [PIX_W-1:0]      dp_data3;
   logic [PIX_W-1:0]      dp_data4;
   logic [SYM_W-1:0]      dp_wm;
   logic [PIX_W-1:0]      dp_result;

   logic                  out_wr_en;
   logic [ADDR_W-1:0]     out_wr_addr;
   logic [PIX_W-1:0]      out_wr_data;

   modport master (
      output cover_rd_en, cover_rd_addr,
      input  cover_rd_data,
      output wm_rd_en, wm_rd_addr,
      input  wm_rd_data,
      output dp_a1, dp_a2,
      output dp_data1, dp_data2, dp_data3, dp_data4, dp_wm,
      input  dp_result,
      output out_wr_en, out_wr_addr, out_wr_data
   );

   modport slave (
      input  cover_rd_en, cover_rd_addr,
      output cover_rd_data,
      input  wm_rd_en, wm_rd_addr,
      output wm_rd_data,
      input  dp_a1, dp_a2,
      input  dp_data1, dp_data2, dp_data3, dp_data4, dp_wm,
      output dp_result,
      input  out_wr_en, out_wr_addr, out_wr_data
   );

endinterface

// File: rtl/wm_insert_addr_gen.sv
// Raster position and clamped neighbour addresses for the sequencer.
// Ports: clr/adv control, pix_n, cur/left/up/ul addresses, last flag.
module wm_insert_addr_gen #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   output logic [ADDR_W-1:0] pix_n,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [ADDR_W-1:0] left_addr,
   output logic [ADDR_W-1:0] up_addr,
   output logic [ADDR_W-1:0] ul_addr,
   output logic              last
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(IMG_W*IMG_H - 1);
   localparam logic [ADDR_W-1:0] ROW    = ADDR_W'(IMG_W);

   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [ADDR_W-1:0] n_q;
   logic              x_last;
   logic              y_last;

   assign x_last = (x_q == XW'(IMG_W - 1));
   assign y_last = (y_q == YW'(IMG_H - 1));
   assign last   = (n_q == N_LAST);

   // n is kept as its own counter so no y*IMG_W multiply is needed;
   // everything wraps to zero after the last pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
         n_q <= '0;
      end else if (clr) begin
         x_q <= '0;
         y_q <= '0;
         n_q <= '0;
      end else if (adv) begin
         n_q <= last ? '0 : n_q + 1'b1;
         if (x_last) begin
            x_q <= '0;
            y_q <= y_last ? '0 : y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   // Edge pixels re-read themselves in place of a missing neighbour.
   assign pix_n     = n_q;
   assign cur_addr  = n_q;
   assign left_addr = (x_q == '0) ? n_q : n_q - 1'b1;
   assign up_addr   = (y_q == '0) ? n_q : n_q - ROW;
   assign ul_addr   = (x_q == '0) ? up_addr : up_addr - 1'b1;

endmodule

// File: rtl/wm_insert_ctrl.sv
// Watermark insertion sequencer: fetches pixels and symbols, drives the
// datapath and writes results. Ports: clk/rst, start/busy/done, a1/a2, bus.
module wm_insert_ctrl
   import wm_insert_ctrl_pkg::*;
#(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12,
   parameter int DP_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic [PIX_W-1:0] a1_in,
   input  logic [PIX_W-1:0] a2_in,
   wm_insert_ctrl_if.master bus
);

   localparam int LAT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

   state_t            state_q;
   state_t            state_d;
   logic [LAT_W-1:0]  exec_q;
   logic              exec_end;
   logic              clr;
   logic              adv;

   logic [ADDR_W-1:0] pix_n;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] left_addr;
   logic [ADDR_W-1:0] up_addr;
   logic [ADDR_W-1:0] ul_addr;
   logic              last;
   logic              last_q;
   logic [ADDR_W-1:0] wr_addr_q;

   logic [PIX_W-1:0]  wm_byte;
   logic [PIX_W-1:0]  cur_q;
   logic [PIX_W-1:0]  left_q;
   logic [PIX_W-1:0]  up_q;

   logic              nx_busy;
   logic              nx_done;
   logic              nx_wm_en;
   logic              nx_cover_en;
   logic [ADDR_W-1:0] nx_cover_addr;

   wm_insert_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .adv       (adv),
      .pix_n     (pix_n),
      .cur_addr  (cur_addr),
      .left_addr (left_addr),
      .up_addr   (up_addr),
      .ul_addr   (ul_addr),
      .last      (last)
   );

   assign exec_end = (exec_q == LAT_W'(DP_LAT - 1));
   assign clr      = (state_q == IDLE) && start;
   // Position advances as EXEC ends, so in WR it already names the
   // next pixel; the pixel being written is held in wr_addr_q/last_q.
   assign adv      = (state_q == EXEC) && exec_end;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RD_WM;
         RD_WM:   state_d = RD_CUR;
         RD_CUR:  state_d = RD_L;
         RD_L:    state_d = RD_U;
         RD_U:    state_d = RD_UL;
         RD_UL:   state_d = CAP;
         CAP:     state_d = EXEC;
         EXEC:    if (exec_end) state_d = WR;
         WR: begin
            if (last_q)
               state_d = DONE;
            else if (pix_n[1:0] == 2'd0)
               state_d = RD_WM;
            else
               state_d = RD_CUR;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so the registered
   // outputs line up with the state they belong to.
   always_comb begin
      nx_cover_en   = 1'b0;
      nx_cover_addr = '0;
      unique case (state_d)
         RD_CUR: begin
            nx_cover_en   = 1'b1;
            nx_cover_addr = cur_addr;
         end
         RD_L: begin
            nx_cover_en   = 1'b1;
            nx_cover_addr = left_addr;
         end
         RD_U: begin
            nx_cover_en   = 1'b1;
            nx_cover_addr = up_addr;
         end
         RD_UL: begin
            nx_cover_en   = 1'b1;
            nx_cover_addr = ul_addr;
         end
         default: ;
      endcase
      nx_wm_en = (state_d == RD_WM);
      nx_busy  = !(state_d inside {IDLE, DONE});
      nx_done  = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= IDLE;
         busy              <= 1'b0;
         done              <= 1'b0;
         exec_q            <= '0;
         last_q            <= 1'b0;
         wr_addr_q         <= '0;
         wm_byte           <= '0;
         cur_q             <= '0;
         left_q            <= '0;
         up_q              <= '0;
         bus.cover_rd_en   <= 1'b0;
         bus.cover_rd_addr <= '0;
         bus.wm_rd_en      <= 1'b0;
         bus.wm_rd_addr    <= '0;
         bus.dp_a1         <= '0;
         bus.dp_a2         <= '0;
         bus.dp_data1      <= '0;
         bus.dp_data2      <= '0;
         bus.dp_data3      <= '0;
         bus.dp_data4      <= '0;
         bus.dp_wm         <= '0;
         bus.out_wr_en     <= 1'b0;
         bus.out_wr_addr   <= '0;
         bus.out_wr_data   <= '0;
      end else begin
         state_q           <= state_d;
         busy              <= nx_busy;
         done              <= nx_done;
         bus.cover_rd_en   <= nx_cover_en;
         bus.cover_rd_addr <= nx_cover_addr;
         bus.wm_rd_en      <= nx_wm_en;
         bus.wm_rd_addr    <= nx_wm_en ? pix_n[ADDR_W-1:2] : '0;
         bus.out_wr_en     <= (state_q == WR);

         if (clr) begin
            bus.dp_a1 <= a1_in;
            bus.dp_a2 <= a2_in;
         end

         if (state_q == CAP)
            exec_q <= '0;
         else if (state_q == EXEC)
            exec_q <= exec_q + 1'b1;

         // Each RAM byte is taken the state after its strobe.
         if (state_q == RD_CUR && pix_n[1:0] == 2'd0)
            wm_byte <= bus.wm_rd_data;
         if (state_q == RD_L)
            cur_q <= bus.cover_rd_data;
         if (state_q == RD_U)
            left_q <= bus.cover_rd_data;
         if (state_q == RD_UL)
            up_q <= bus.cover_rd_data;

         if (state_q == CAP) begin
            bus.dp_data1 <= cur_q;
            bus.dp_data2 <= left_q;
            bus.dp_data3 <= up_q;
            bus.dp_data4 <= bus.cover_rd_data;
            bus.dp_wm    <= sym_sel(wm_byte, pix_n[1:0]);
            wr_addr_q    <= pix_n;
            last_q       <= last;
         end

         // dp_result is only settled during WR, so the write is
         // registered on the edge that closes WR.
         if (state_q == WR) begin
            bus.out_wr_addr <= wr_addr_q;
            bus.out_wr_data <= bus.dp_result;
         end
      end
   end

endmodule

// File: tb/tb_wm_insert_ctrl.sv
// Bench for wm_insert_ctrl: random cover/wm images, RAM and datapath
// models, and a raster reference for reads, writes and timing.
module tb_wm_insert_ctrl;
   import wm_insert_ctrl_pkg::*;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 2;
   localparam int ADDR_W = 12;
   localparam int DP_LAT = 2;
   localparam int N      = IMG_W * IMG_H;

   typedef struct {
      int addr;
      int data;
      int d2;
      int d3;
      int d4;
      int wm;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] a1_in = 8'h00;
   logic [7:0] a2_in = 8'h00;

   wm_insert_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   wm_insert_ctrl #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W),
      .DP_LAT (DP_LAT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .a1_in (a1_in),
      .a2_in (a2_in),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   logic [7:0] cover_mem [N];
   logic [7:0] wm_mem [N/4];
   logic [7:0] pipe [DP_LAT];

   always @(posedge clk) begin
      if (bus.cover_rd_en)
         bus.cover_rd_data <= cover_mem[int'(bus.cover_rd_addr) % N];
      if (bus.wm_rd_en)
         bus.wm_rd_data <= wm_mem[int'(bus.wm_rd_addr) % (N/4)];
   end

   always @(posedge clk) begin
      pipe[0] <= bus.dp_data1 ^ {6'b0, bus.dp_wm};
      for (int i = 1; i < DP_LAT; i++)
         pipe[i] <= pipe[i-1];
   end
   assign bus.dp_result = pipe[DP_LAT-1];

   wr_t wr_q[$];
   int  rd_q[$];
   int  wmrd_q[$];
   int  busy_cnt = 0;
   int  done_cnt = 0;
   int  both_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (busy && done) both_cnt++;
         if (bus.cover_rd_en) rd_q.push_back(int'(bus.cover_rd_addr));
         if (bus.wm_rd_en) wmrd_q.push_back(int'(bus.wm_rd_addr));
         if (bus.out_wr_en)
            wr_q.push_back(wr_t'{int'(bus.out_wr_addr),
                                 int'(bus.out_wr_data),
                                 int'(bus.dp_data2),
                                 int'(bus.dp_data3),
                                 int'(bus.dp_data4),
                                 int'(bus.dp_wm)});
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference: symbol k of byte n/4, LSB first.
   function automatic int sym(input int n);
      return (int'(wm_mem[n/4]) >> (2*(n%4))) & 3;
   endfunction

   // Reference: k=0 cur, 1 left, 2 up, 3 up-left, clamped at edges.
   function automatic int nb(input int n, input int k);
      int x;
      int y;
      x = n % IMG_W;
      y = n / IMG_W;
      if ((k == 1 || k == 3) && x > 0) x = x - 1;
      if (k >= 2 && y > 0) y = y - 1;
      return y*IMG_W + x;
   endfunction

   task automatic fill(input bit directed);
      for (int i = 0; i < N; i++)
         cover_mem[i] = directed ? 8'(i) : 8'($urandom_range(0, 255));
      for (int i = 0; i < N/4; i++)
         wm_mem[i] = 8'($urandom_range(0, 255));
      if (directed) wm_mem[0] = 8'hE4;
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_rd"}, 32'({bus.cover_rd_en, bus.wm_rd_en,
                               bus.out_wr_en}), 0);
   endtask

   task automatic run_frame(input string tag, input bit repulse,
                            input logic [7:0] a1, input logic [7:0] a2);
      int wb;
      int rb;
      int mb;
      int bb;
      int db;
      int t;
      wb = wr_q.size();
      rb = rd_q.size();
      mb = wmrd_q.size();
      bb = busy_cnt;
      db = done_cnt;
      a1_in = a1;
      a2_in = a2;
      start = 1'b1;
      tick();
      start = 1'b0;
      a1_in = ~a1;
      a2_in = ~a2;
      t = 0;
      while (done_cnt == db && t < 3000) begin
         tick();
         t++;
         start = repulse && (t == 20);
      end
      start = 1'b0;
      repeat (3) tick();
      check({tag, "_done_pulses"}, done_cnt - db, 1);
      check({tag, "_busy_cycles"}, busy_cnt - bb,
            N*(6+DP_LAT) + N/4);
      check({tag, "_busy_done"}, both_cnt, 0);
      check({tag, "_wr_count"}, wr_q.size() - wb, N);
      for (int i = 0; i < N; i++) begin
         if (wb + i < wr_q.size()) begin
            check($sformatf("%s_wr%0d_addr", tag, i), wr_q[wb+i].addr, i);
            check($sformatf("%s_wr%0d_data", tag, i), wr_q[wb+i].data,
                  int'(cover_mem[i]) ^ sym(i));
            check($sformatf("%s_wr%0d_left", tag, i), wr_q[wb+i].d2,
                  int'(cover_mem[nb(i, 1)]));
            check($sformatf("%s_wr%0d_up", tag, i), wr_q[wb+i].d3,
                  int'(cover_mem[nb(i, 2)]));
            check($sformatf("%s_wr%0d_ul", tag, i), wr_q[wb+i].d4,
                  int'(cover_mem[nb(i, 3)]));
            check($sformatf("%s_wr%0d_wm", tag, i), wr_q[wb+i].wm, sym(i));
         end
      end
      check({tag, "_rd_count"}, rd_q.size() - rb, 4*N);
      for (int i = 0; i < 4*N; i++)
         if (rb + i < rd_q.size())
            check($sformatf("%s_rd%0d", tag, i), rd_q[rb+i], nb(i/4, i%4));
      check({tag, "_wm_count"}, wmrd_q.size() - mb, N/4);
      for (int i = 0; i < N/4; i++)
         if (mb + i < wmrd_q.size())
            check($sformatf("%s_wm%0d", tag, i), wmrd_q[mb+i], i);
      check({tag, "_a1"}, 32'(bus.dp_a1), 32'(a1));
      check({tag, "_a2"}, 32'(bus.dp_a2), 32'(a2));
      check_idle_outs({tag, "_after"});
   endtask

   initial begin
      int wb;
      int rb;
      int bb;
      int db;
      int t;

      fill(1'b1);
      tick();
      tick();
      check_idle_outs("in_reset");
      check("in_reset_data", 32'({bus.dp_a1, bus.dp_data1, bus.out_wr_data}), 0);
      rst = 1'b0;
      wb = wr_q.size();
      rb = rd_q.size();
      bb = busy_cnt;
      db = done_cnt;
      repeat (20) tick();
      check("idle_busy_cycles", busy_cnt - bb, 0);
      check("idle_done", done_cnt - db, 0);
      check("idle_writes", wr_q.size() - wb, 0);
      check("idle_reads", rd_q.size() - rb, 0);
      check("idle_addr", 32'({bus.cover_rd_addr, bus.out_wr_addr}), 0);

      run_frame("directed", 1'b1, 8'h33, 8'h55);
      for (int f = 0; f < 3; f++) begin
         fill(1'b0);
         run_frame($sformatf("rand%0d", f), f[0],
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      fill(1'b0);
      wb = wr_q.size();
      db = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (wr_q.size() < wb + 5 && t < 3000) begin
         tick();
         t++;
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_idle_outs("abort");
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("abort_writes", wr_q.size() - wb, 5);
      check("abort_done", done_cnt - db, 0);
      check_idle_outs("abort_idle");

      fill(1'b0);
      run_frame("post_abort", 1'b0, 8'hA5, 8'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
